// File: rtl/uart_pkg.sv
// Shared types and constants for the scheduled UART transmitter.
// The frame format is fixed 8N1.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Clock cycles spent on each bit of the line.
    function automatic int cnt_max(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after last+1.
// Priority order is handled by rotating the request vector, isolating its lowest set bit, then rotating back.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   gnt
);

    logic [IDW-1:0] start;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   gnt_rot;

    always_comb begin
        start   = (last == IDW'(N - 1)) ? '0 : last + 1'b1;
        req_rot = (req >> start) | (req << (N - int'(start)));
        gnt_rot = req_rot & (~req_rot + 1'b1);
        gnt     = (gnt_rot << start) | (gnt_rot >> (N - int'(start)));
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one 8N1 UART transmit line between NUM_SRC byte producers.
// A source is chosen round-robin, its byte is accepted over valid/ready, then it is shifted out LSB first.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int CLK_FREQ = 100_000_000,
    parameter  int BAUD     = 9600,
    parameter  int NUM_SRC  = 4,
    localparam int IDW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   req_valid,
    input  logic [8*NUM_SRC-1:0] req_data,
    output logic [NUM_SRC-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id
);

    localparam int CNT_MAX = cnt_max(CLK_FREQ, BAUD);
    localparam int CW      = $clog2(CNT_MAX);
    localparam int BW      = $clog2(DATA_BITS);

    uart_state_t    state_q, state_d;
    logic [CW-1:0]  baud_q, baud_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic [NUM_SRC-1:0] arb_gnt;
    logic [IDW-1:0]     gnt_idx;
    logic [7:0]         gnt_data;
    logic               handshake;
    logic               baud_wrap;

    rr_arbiter #(
        .N(NUM_SRC)
    ) u_arb (
        .req  (req_valid),
        .last (ptr_q),
        .gnt  (arb_gnt)
    );

    assign req_ready = (state_q == IDLE) ? arb_gnt : '0;
    assign handshake = |(req_valid & req_ready);
    assign baud_wrap = (baud_q == CW'(CNT_MAX - 1));

    // The grant is one-hot, so at most one iteration matches.
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx  = IDW'(i);
                gnt_data = req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;

        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                if (handshake) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    shift_d = gnt_data;
                    gid_d   = gnt_idx;
                    ptr_d   = gnt_idx;
                    bit_d   = '0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                // Each wrap retires one bit; the last one hands over to the stop bit.
                if (baud_wrap) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer resets to the last source so that source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            gid_q   <= '0;
            ptr_q   <= IDW'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_sched;

    localparam int NSRC  = 4;
    localparam int CNT   = 10;
    localparam int FRAME = 10 * CNT;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] req_valid;
    logic [8*NSRC-1:0] req_data;
    logic [NSRC-1:0] req_ready;
    logic            tx;
    logic            busy;
    logic [1:0]      grant_id;

    int cyc = 0;
    int checkCount = 0;
    int errorCount = 0;

    uart_tx_sched #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .NUM_SRC  (NSRC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs just after the rising edge that starts cycle c.
    task automatic applyStimulus(input int c, input logic r, input logic [NSRC-1:0] v);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        rst       = r;
        req_valid = v;
    endtask

    // Move to the falling edge inside cycle c.
    task automatic atCycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Reference model: frame offset 0 means idle, 1..FRAME are the cycles after a handshake.
    function automatic logic [NSRC-1:0] modelReady(input logic [NSRC-1:0] v, input int last, input int off);
        logic [NSRC-1:0] r;
        int idx;
        bit found;
        r = '0;
        found = 1'b0;
        if (off == 0) begin
            for (int k = 1; k <= NSRC; k++) begin
                idx = (last + k) % NSRC;
                if (!found && v[idx]) begin
                    r[idx] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic modelTx(input int off, input logic [7:0] b);
        if (off == 0 || off > 9 * CNT) return 1'b1;
        if (off <= CNT) return 1'b0;
        return b[(off - CNT - 1) / CNT];
    endfunction

    bit         mdlOn = 1'b0;
    int         mOff = 0;
    int         mLast = NSRC - 1;
    int         mGid = 0;
    logic [7:0] mByte = 8'h00;

    always @(negedge clk) begin
        logic [NSRC-1:0] expRdy;
        expRdy = modelReady(req_valid, mLast, mOff);
        if (mdlOn) begin
            checkOutput("mdl_tx", 32'(tx), 32'(modelTx(mOff, mByte)));
            checkOutput("mdl_busy", 32'(busy), 32'(mOff != 0));
            checkOutput("mdl_grant_id", 32'(grant_id), mGid);
            checkOutput("mdl_req_ready", 32'(req_ready), 32'(expRdy));
        end
        if (rst) begin
            mdlOn = 1'b1;
            mOff  = 0;
            mLast = NSRC - 1;
            mGid  = 0;
        end else if (mOff == 0) begin
            for (int i = 0; i < NSRC; i++) begin
                if (expRdy[i]) begin
                    mGid  = i;
                    mLast = i;
                    mByte = req_data[8*i +: 8];
                    mOff  = 1;
                end
            end
        end else begin
            mOff = (mOff == FRAME) ? 0 : mOff + 1;
        end
    end

    // Single 0xA5 frame from src0, handshake in cycle 10.
    int s1Cyc  [13] = '{11, 20, 21, 35, 45, 55, 65, 75, 90, 100, 101, 110, 111};
    int s1Tx   [13] = '{ 0,  0,  1,  0,  1,  0,  0,  1,  0,   1,   1,   1,   1};
    int s1Busy [13] = '{ 1,  1,  1,  1,  1,  1,  1,  1,  1,   1,   1,   1,   0};
    int fairGid[6]  = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = {8'hC3, 8'h5A, 8'hE1, 8'hA5};

        atCycle(2);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
        applyStimulus(3, 1'b0, 4'b0000);

        applyStimulus(10, 1'b0, 4'b0001);
        atCycle(10);
        checkOutput("s1_ready", 32'(req_ready), 32'b0001);
        applyStimulus(11, 1'b0, 4'b0000);
        for (int i = 0; i < 13; i++) begin
            atCycle(s1Cyc[i]);
            checkOutput("s1_tx", 32'(tx), s1Tx[i]);
            checkOutput("s1_busy", 32'(busy), s1Busy[i]);
        end

        // src2 raised mid-frame must wait for the first idle cycle.
        applyStimulus(120, 1'b0, 4'b0001);
        applyStimulus(121, 1'b0, 4'b0000);
        applyStimulus(150, 1'b0, 4'b0100);
        atCycle(150);
        checkOutput("s3_ready_mid", 32'(req_ready), 32'd0);
        atCycle(220);
        checkOutput("s3_ready_end", 32'(req_ready), 32'd0);
        checkOutput("s3_busy_end", 32'(busy), 32'd1);
        atCycle(221);
        checkOutput("s3_ready_idle", 32'(req_ready), 32'b0100);
        checkOutput("s3_busy_idle", 32'(busy), 32'd0);
        applyStimulus(222, 1'b0, 4'b0000);
        atCycle(222);
        checkOutput("s3_grant_id", 32'(grant_id), 32'd2);
        checkOutput("s3_start", 32'(tx), 32'd0);
        atCycle(232);
        checkOutput("s3_bit0", 32'(tx), 32'd0);
        atCycle(242);
        checkOutput("s3_bit1", 32'(tx), 32'd1);

        // After src3 is served, src1 beats src3.
        applyStimulus(330, 1'b0, 4'b1000);
        atCycle(330);
        checkOutput("s4_ready_src3", 32'(req_ready), 32'b1000);
        applyStimulus(331, 1'b0, 4'b0000);
        applyStimulus(431, 1'b0, 4'b1010);
        atCycle(431);
        checkOutput("s4_ready_src1", 32'(req_ready), 32'b0010);
        applyStimulus(432, 1'b0, 4'b0000);
        atCycle(432);
        checkOutput("s4_grant_id", 32'(grant_id), 32'd1);

        // Request withdrawn while busy leaves no trace.
        applyStimulus(540, 1'b0, 4'b0001);
        applyStimulus(541, 1'b0, 4'b0000);
        applyStimulus(560, 1'b0, 4'b0010);
        atCycle(560);
        checkOutput("s6_ready_busy", 32'(req_ready), 32'd0);
        applyStimulus(563, 1'b0, 4'b0000);
        atCycle(645);
        checkOutput("s6_tx", 32'(tx), 32'd1);
        checkOutput("s6_busy", 32'(busy), 32'd0);
        checkOutput("s6_ready", 32'(req_ready), 32'd0);
        checkOutput("s6_grant_id", 32'(grant_id), 32'd0);

        // Reset at frame cycle 45 truncates the frame and restores src0-first priority.
        applyStimulus(660, 1'b0, 4'b0100);
        applyStimulus(661, 1'b0, 4'b0000);
        applyStimulus(705, 1'b1, 4'b0000);
        atCycle(705);
        checkOutput("s5_busy_before", 32'(busy), 32'd1);
        applyStimulus(706, 1'b0, 4'b0000);
        atCycle(706);
        checkOutput("s5_tx", 32'(tx), 32'd1);
        checkOutput("s5_busy", 32'(busy), 32'd0);
        checkOutput("s5_ready", 32'(req_ready), 32'd0);
        checkOutput("s5_grant_id", 32'(grant_id), 32'd0);
        applyStimulus(708, 1'b0, 4'b1010);
        atCycle(708);
        checkOutput("s5_ready_low", 32'(req_ready), 32'b0010);
        applyStimulus(709, 1'b0, 4'b0000);
        atCycle(709);
        checkOutput("s5_grant_low", 32'(grant_id), 32'd1);

        // All four continuously valid: back-to-back frames every FRAME+1 cycles.
        applyStimulus(815, 1'b1, 4'b0000);
        applyStimulus(816, 1'b0, 4'b0000);
        applyStimulus(820, 1'b0, 4'b1111);
        for (int j = 0; j < 6; j++) begin
            atCycle(820 + (FRAME + 1) * j);
            checkOutput("s2_ready_pulse", 32'(req_ready), 32'd1 << fairGid[j]);
            atCycle(821 + (FRAME + 1) * j);
            checkOutput("s2_ready_drop", 32'(req_ready), 32'd0);
            checkOutput("s2_grant_id", 32'(grant_id), fairGid[j]);
        end
        applyStimulus(1327, 1'b0, 4'b0000);

        atCycle(1440);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
